// File: rtl/regfile_sb_pkg.sv
// Shared constants for the integer register file and its ALU neighbour.
// Register count/width defaults, the x0 index, and the ALU function codes.
package regfile_sb_pkg;

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;
    localparam int RF_AW   = 5;
    localparam int RF_X0   = 0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one bit per architectural register, x0 excluded.
// Issue sets, writeback clears; a set and clear of the same register resolve to set.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int AW   = RF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic          clr_valid,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_pending,
    output logic          rs2_pending,
    output logic          issue_ready
);

    localparam logic [AW-1:0] X0 = AW'(RF_X0);

    logic [NREG-1:1] pending;

    function automatic logic lookup(input logic [AW-1:0] a, input logic [NREG-1:1] p);
        return (a == X0) ? 1'b0 : p[a];
    endfunction

    always_comb begin
        rs1_pending = lookup(rs1_addr, pending);
        rs2_pending = lookup(rs2_addr, pending);
        issue_ready = !lookup(issue_rd, pending);
    end

    // Set is applied after clear so it wins on a same-register collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_valid && clr_rd != X0)
                pending[clr_rd] <= 1'b0;
            if (issue_valid && issue_ready && issue_rd != X0)
                pending[issue_rd] <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// RV32I integer register file with write-pending scoreboard for RAW/WAW stalls.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG,
    parameter int AW   = RF_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [AW-1:0] X0 = AW'(RF_X0);

    logic [XLEN-1:0] regs [1:NREG-1];
    logic [XLEN-1:0] rs1_arr;
    logic [XLEN-1:0] rs2_arr;
    logic            rs1_pending;
    logic            rs2_pending;

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .clr_valid   (wb_valid),
        .clr_rd      (wb_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .issue_ready (issue_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_valid && wb_rd != X0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_arr = (rs1_addr == X0) ? '0 : regs[rs1_addr];
        rs2_arr = (rs2_addr == X0) ? '0 : regs[rs2_addr];
    end

`ifdef REGFILE_BYPASS_EN
    // Writebacks arriving during reset are discarded, so they must not forward either.
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = !rst && wb_valid && (wb_rd == rs1_addr) && (rs1_addr != X0);
    assign rs2_hit  = !rst && wb_valid && (wb_rd == rs2_addr) && (rs2_addr != X0);
    assign rs1_data = rs1_hit ? wb_data : rs1_arr;
    assign rs2_data = rs2_hit ? wb_data : rs2_arr;
    assign rs1_busy = rs1_pending && !rs1_hit;
    assign rs2_busy = rs2_pending && !rs2_hit;
`else
    assign rs1_data = rs1_arr;
    assign rs2_data = rs2_arr;
    assign rs1_busy = rs1_pending;
    assign rs2_busy = rs2_pending;
`endif

endmodule
